// File: rtl/radix2_bfly_pipe.sv
// Three-stage complex radix-2 butterfly (DIT/DIF) with optional 1/2 scaling, saturation,
// sticky overflow and a valid/ready pipeline that collapses bubbles under backpressure.
module radix2_bfly_pipe #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [DATA_W-1:0] i_a_re,
    input  logic signed [DATA_W-1:0] i_a_im,
    input  logic signed [DATA_W-1:0] i_b_re,
    input  logic signed [DATA_W-1:0] i_b_im,
    input  logic signed [TW_W-1:0]   i_tw_re,
    input  logic signed [TW_W-1:0]   i_tw_im,
    input  logic                     i_mode,
    input  logic                     i_scale,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [DATA_W-1:0] o_x0_re,
    output logic signed [DATA_W-1:0] o_x0_im,
    output logic signed [DATA_W-1:0] o_x1_re,
    output logic signed [DATA_W-1:0] o_x1_im,
    output logic                     o_ovf,
    input  logic                     i_clr_ovf
);

    localparam int WW = DATA_W + TW_W + 2;
    localparam int GW = DATA_W + 1;

    typedef logic signed [WW-1:0] wide_t;

    function automatic wide_t clamp(input wide_t x, input int bits);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic clips(input wide_t x, input int bits);
        return clamp(x, bits) != x;
    endfunction

    // Round half-up, then drop the Q1.(TW_W-1) fraction.
    function automatic wide_t rnd(input wide_t acc);
        return (acc + (wide_t'(1) <<< (TW_W - 2))) >>> (TW_W - 1);
    endfunction

    function automatic wide_t half(input wide_t s, input logic en);
        return en ? ((s + wide_t'(1)) >>> 1) : s;
    endfunction

    logic v1_q, v2_q, v3_q;
    logic adv1, adv2, adv3;

    assign adv3    = !v3_q || i_ready;
    assign adv2    = !v2_q || adv3;
    assign adv1    = !v1_q || adv2;
    assign o_ready = adv1;
    assign o_valid = v3_q;

    // Stage 1: DIT forms P = B*W; DIF forms X0 = A+B and D = A-B.
    logic signed [DATA_W-1:0] s1_x_re_d, s1_x_im_d, s1_x_re_q, s1_x_im_q;
    logic signed [GW-1:0]     s1_y_re_d, s1_y_im_d, s1_y_re_q, s1_y_im_q;
    logic signed [TW_W-1:0]   s1_w_re_q, s1_w_im_q;
    logic                     s1_mode_q, s1_scale_q, s1_ovf_d, s1_ovf_q;

    wide_t a_re, a_im, b_re, b_im, w_re, w_im;
    wide_t p_re, p_im, sum_re, sum_im, dif_re, dif_im;

    always_comb begin
        a_re   = wide_t'(i_a_re);
        a_im   = wide_t'(i_a_im);
        b_re   = wide_t'(i_b_re);
        b_im   = wide_t'(i_b_im);
        w_re   = wide_t'(i_tw_re);
        w_im   = wide_t'(i_tw_im);
        p_re   = rnd(b_re * w_re - b_im * w_im);
        p_im   = rnd(b_re * w_im + b_im * w_re);
        sum_re = half(a_re + b_re, i_scale);
        sum_im = half(a_im + b_im, i_scale);
        dif_re = half(a_re - b_re, i_scale);
        dif_im = half(a_im - b_im, i_scale);
        if (i_mode) begin
            s1_x_re_d = DATA_W'(clamp(sum_re, DATA_W));
            s1_x_im_d = DATA_W'(clamp(sum_im, DATA_W));
            s1_y_re_d = GW'(clamp(dif_re, DATA_W));
            s1_y_im_d = GW'(clamp(dif_im, DATA_W));
            s1_ovf_d  = clips(sum_re, DATA_W) || clips(sum_im, DATA_W) ||
                        clips(dif_re, DATA_W) || clips(dif_im, DATA_W);
        end else begin
            // P keeps one guard bit so A-P can still reach the negative rail.
            s1_x_re_d = i_a_re;
            s1_x_im_d = i_a_im;
            s1_y_re_d = GW'(clamp(p_re, GW));
            s1_y_im_d = GW'(clamp(p_im, GW));
            s1_ovf_d  = clips(p_re, GW) || clips(p_im, GW);
        end
    end

    // Stage 2: DIT forms A+P / A-P; DIF forms X1 = D*W.
    logic signed [DATA_W-1:0] s2_x0_re_d, s2_x0_im_d, s2_x1_re_d, s2_x1_im_d;
    logic signed [DATA_W-1:0] s2_x0_re_q, s2_x0_im_q, s2_x1_re_q, s2_x1_im_q;
    logic                     s2_ovf_d, s2_ovf_q;

    wide_t x_re, x_im, y_re, y_im, v_re, v_im;
    wide_t t0_re, t0_im, t1_re, t1_im, m_re, m_im;

    always_comb begin
        x_re  = wide_t'(s1_x_re_q);
        x_im  = wide_t'(s1_x_im_q);
        y_re  = wide_t'(s1_y_re_q);
        y_im  = wide_t'(s1_y_im_q);
        v_re  = wide_t'(s1_w_re_q);
        v_im  = wide_t'(s1_w_im_q);
        t0_re = half(x_re + y_re, s1_scale_q);
        t0_im = half(x_im + y_im, s1_scale_q);
        t1_re = half(x_re - y_re, s1_scale_q);
        t1_im = half(x_im - y_im, s1_scale_q);
        m_re  = rnd(y_re * v_re - y_im * v_im);
        m_im  = rnd(y_re * v_im + y_im * v_re);
        if (s1_mode_q) begin
            s2_x0_re_d = s1_x_re_q;
            s2_x0_im_d = s1_x_im_q;
            s2_x1_re_d = DATA_W'(clamp(m_re, DATA_W));
            s2_x1_im_d = DATA_W'(clamp(m_im, DATA_W));
            s2_ovf_d   = s1_ovf_q || clips(m_re, DATA_W) || clips(m_im, DATA_W);
        end else begin
            s2_x0_re_d = DATA_W'(clamp(t0_re, DATA_W));
            s2_x0_im_d = DATA_W'(clamp(t0_im, DATA_W));
            s2_x1_re_d = DATA_W'(clamp(t1_re, DATA_W));
            s2_x1_im_d = DATA_W'(clamp(t1_im, DATA_W));
            s2_ovf_d   = s1_ovf_q || clips(t0_re, DATA_W) || clips(t0_im, DATA_W) ||
                         clips(t1_re, DATA_W) || clips(t1_im, DATA_W);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (adv1) v1_q <= i_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (adv1 && i_valid) begin
            s1_x_re_q  <= s1_x_re_d;
            s1_x_im_q  <= s1_x_im_d;
            s1_y_re_q  <= s1_y_re_d;
            s1_y_im_q  <= s1_y_im_d;
            s1_w_re_q  <= i_tw_re;
            s1_w_im_q  <= i_tw_im;
            s1_mode_q  <= i_mode;
            s1_scale_q <= i_scale;
            s1_ovf_q   <= s1_ovf_d;
        end
        if (adv2 && v1_q) begin
            s2_x0_re_q <= s2_x0_re_d;
            s2_x0_im_q <= s2_x0_im_d;
            s2_x1_re_q <= s2_x1_re_d;
            s2_x1_im_q <= s2_x1_im_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    logic s3_ovf_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_x0_re  <= '0;
            o_x0_im  <= '0;
            o_x1_re  <= '0;
            o_x1_im  <= '0;
            s3_ovf_q <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            if (adv3 && v2_q) begin
                o_x0_re  <= s2_x0_re_q;
                o_x0_im  <= s2_x0_im_q;
                o_x1_re  <= s2_x1_re_q;
                o_x1_im  <= s2_x1_im_q;
                s3_ovf_q <= s2_ovf_q;
            end
            // A saturating beat leaving in the same cycle as a clear keeps the flag set.
            o_ovf <= (o_ovf && !i_clr_ovf) || (v3_q && i_ready && s3_ovf_q);
        end
    end

endmodule

// File: tb/tb_radix2_bfly_pipe.sv
// Bench for radix2_bfly_pipe: directed test-plan beats, backpressure, reset mid-stream and a
// randomized handshake phase scored against an arithmetic reference model.
module tb_radix2_bfly_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, i_valid, o_ready, i_mode, i_scale, o_valid, i_ready;
    logic                 o_ovf, i_clr_ovf;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [DW-1:0] x0_re, x0_im, x1_re, x1_im;

    radix2_bfly_pipe #(.DATA_W(DW), .TW_W(TW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a_re   (a_re),
        .i_a_im   (a_im),
        .i_b_re   (b_re),
        .i_b_im   (b_im),
        .i_tw_re  (w_re),
        .i_tw_im  (w_im),
        .i_mode   (i_mode),
        .i_scale  (i_scale),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_x0_re  (x0_re),
        .o_x0_im  (x0_im),
        .o_x1_re  (x1_re),
        .o_x1_im  (x1_im),
        .o_ovf    (o_ovf),
        .i_clr_ovf(i_clr_ovf)
    );

    typedef struct {
        int x0re;
        int x0im;
        int x1re;
        int x1im;
        bit ovf;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   outs = 0;
    bit   ovf_m = 1'b0;
    bit   in_acc = 1'b0;
    bit   ordy_s = 1'b1;
    bit   stall_prev = 1'b0;
    int   hold[4];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Floor division so every rounding step below is plain integer arithmetic.
    function automatic longint fdiv(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic longint lim(input longint v, input int bits, inout bit o);
        longint hi;
        hi = (longint'(1) << (bits - 1)) - 1;
        if (v > hi) begin o = 1'b1; return hi; end
        if (v < -hi - 1) begin o = 1'b1; return -hi - 1; end
        return v;
    endfunction

    function automatic longint qround(input longint v);
        return fdiv(v + (longint'(1) << (TW - 2)), longint'(1) << (TW - 1));
    endfunction

    function automatic longint sc2(input longint s, input bit sc);
        return sc ? fdiv(s + 1, 2) : s;
    endfunction

    function automatic res_t model(input int ar, input int ai, input int br, input int bi,
                                   input int wr, input int wi, input bit mode, input bit sc);
        res_t   r;
        bit     o;
        longint pr, pi, dr, di;
        o = 1'b0;
        if (!mode) begin
            pr     = lim(qround(longint'(br) * wr - longint'(bi) * wi), DW + 1, o);
            pi     = lim(qround(longint'(br) * wi + longint'(bi) * wr), DW + 1, o);
            r.x0re = int'(lim(sc2(ar + pr, sc), DW, o));
            r.x0im = int'(lim(sc2(ai + pi, sc), DW, o));
            r.x1re = int'(lim(sc2(ar - pr, sc), DW, o));
            r.x1im = int'(lim(sc2(ai - pi, sc), DW, o));
        end else begin
            r.x0re = int'(lim(sc2(longint'(ar) + br, sc), DW, o));
            r.x0im = int'(lim(sc2(longint'(ai) + bi, sc), DW, o));
            dr     = lim(sc2(longint'(ar) - br, sc), DW, o);
            di     = lim(sc2(longint'(ai) - bi, sc), DW, o);
            r.x1re = int'(lim(qround(dr * wr - di * wi), DW, o));
            r.x1im = int'(lim(qround(dr * wi + di * wr), DW, o));
        end
        r.ovf = o;
        return r;
    endfunction

    // One clock: score both handshakes at the negedge, then return 1 time unit past posedge.
    task automatic tick();
        res_t e;
        bit   xo;
        @(negedge clk);
        in_acc = 1'b0;
        ordy_s = o_ready;
        xo     = 1'b0;
        if (!rst_n) begin
            q.delete();
            ovf_m      = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("ovf_flag", int'(o_ovf), int'(ovf_m));
            if (stall_prev) begin
                check("hold_valid", int'(o_valid), 1);
                check("hold_x0re", int'(x0_re), hold[0]);
                check("hold_x0im", int'(x0_im), hold[1]);
                check("hold_x1re", int'(x1_re), hold[2]);
                check("hold_x1im", int'(x1_im), hold[3]);
            end
            if (o_valid && i_ready) begin
                check("out_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("x0re", int'(x0_re), e.x0re);
                    check("x0im", int'(x0_im), e.x0im);
                    check("x1re", int'(x1_re), e.x1re);
                    check("x1im", int'(x1_im), e.x1im);
                    xo = e.ovf;
                    outs++;
                end
            end
            ovf_m = (ovf_m && !i_clr_ovf) || xo;
            if (i_valid && o_ready) begin
                q.push_back(model(int'(a_re), int'(a_im), int'(b_re), int'(b_im),
                                  int'(w_re), int'(w_im), i_mode, i_scale));
                in_acc = 1'b1;
            end
            stall_prev = o_valid && !i_ready;
            hold[0] = int'(x0_re);
            hold[1] = int'(x0_im);
            hold[2] = int'(x1_re);
            hold[3] = int'(x1_im);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi, input bit mode, input bit sc);
        a_re    = DW'(ar);
        a_im    = DW'(ai);
        b_re    = DW'(br);
        b_im    = DW'(bi);
        w_re    = TW'(wr);
        w_im    = TW'(wi);
        i_mode  = mode;
        i_scale = sc;
    endtask

    function automatic int rval();
        int k;
        k = int'($urandom_range(0, 7));
        if (k == 0) return -32768;
        if (k == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic rdrive();
        drive(rval(), rval(), rval(), rval(), rval(), rval(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    endtask

    task automatic single(input string tag, input int ar, input int ai, input int br,
                          input int bi, input int wr, input int wi, input bit mode,
                          input bit sc, input int e0r, input int e0i, input int e1r,
                          input int e1i, input bit eovf, input bit clr_at_exit);
        int lat;
        i_ready = 1'b1;
        drive(ar, ai, br, bi, wr, wi, mode, sc);
        i_valid = 1'b1;
        tick();
        check({tag, "_accept"}, int'(in_acc), 1);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_x0re"}, int'(x0_re), e0r);
        check({tag, "_x0im"}, int'(x0_im), e0i);
        check({tag, "_x1re"}, int'(x1_re), e1r);
        check({tag, "_x1im"}, int'(x1_im), e1i);
        i_clr_ovf = clr_at_exit;
        tick();
        i_clr_ovf = 1'b0;
        check({tag, "_ovf"}, int'(o_ovf), int'(eovf));
    endtask

    initial begin
        int fall;
        int idx;
        int outs0;

        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_clr_ovf = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        tick();
        tick();
        check("rst_valid", int'(o_valid), 0);
        check("rst_x0re", int'(x0_re), 0);
        check("rst_x1im", int'(x1_im), 0);
        check("rst_ovf", int'(o_ovf), 0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", int'(o_ready), 1);

        single("dit", 100, 50, 1000, 0, 32767, 0, 1'b0, 1'b0, 1100, 50, -900, 50, 1'b0, 1'b0);
        single("dit_sc", 100, 50, 1000, 0, 32767, 0, 1'b0, 1'b1, 550, 25, -450, 25, 1'b0, 1'b0);
        single("dit_mj", 0, 0, 1000, 200, 0, -32768, 1'b0, 1'b0, 200, -1000, -200, 1000, 1'b0,
               1'b0);
        single("sat", 0, 0, -32768, 0, -32768, 0, 1'b0, 1'b0, 32767, 0, -32768, 0, 1'b1, 1'b0);
        single("sat_clr", 0, 0, -32768, 0, -32768, 0, 1'b0, 1'b0, 32767, 0, -32768, 0, 1'b1,
               1'b1);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        check("clr_ovf", int'(o_ovf), 0);
        single("dif", 3000, 0, 1000, 0, 0, -32768, 1'b1, 1'b0, 4000, 0, 0, -2000, 1'b0, 1'b0);

        // Backpressure: downstream stalled for the first 8 cycles of an 8-beat stream.
        fall  = -1;
        idx   = 0;
        outs0 = outs;
        for (int c = 0; c < 60 && !(idx == 8 && q.size() == 0); c++) begin
            i_ready = (c >= 8);
            i_valid = (idx < 8);
            drive(1000 * idx + 7, -300 * idx, 50 * idx, 11 + idx, 16384, -8192, idx[0], 1'b0);
            tick();
            if (in_acc) idx++;
            if (!ordy_s && fall < 0) fall = idx;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("bp_fill", fall, 3);
        check("bp_count", outs - outs0, 8);
        check("bp_drained", q.size(), 0);

        // Reset with three beats in flight and the flag set.
        single("sat2", 0, 0, -32768, 0, -32768, 0, 1'b0, 1'b0, 32767, 0, -32768, 0, 1'b1, 1'b0);
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            drive(5000 + k, 1, 2, 3, 32767, 0, 1'b0, 1'b0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_x0re", int'(x0_re), 0);
        check("mid_rst_x0im", int'(x0_im), 0);
        check("mid_rst_x1re", int'(x1_re), 0);
        check("mid_rst_ovf", int'(o_ovf), 0);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        #1;
        check("mid_rst_ready", int'(o_ready), 1);
        outs0 = outs;
        for (int k = 0; k < 10; k++) tick();
        check("no_stale", outs - outs0, 0);

        // Randomized handshake and data.
        for (int c = 0; c < 400; c++) begin
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 2) != 0);
            i_clr_ovf = ($urandom_range(0, 15) == 0);
            rdrive();
            tick();
        end
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_clr_ovf = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        check("rand_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radix2_bfly_pipe.md
# radix2_bfly_pipe

Parametrised, pipelined complex radix-2 butterfly for the FFT datapath. It accepts one butterfly per cycle: operands A and B plus a twiddle W. It produces X0/X1 in DIT mode (twiddle before add/sub) or DIF mode (twiddle after add/sub), with optional per-stage 1/2 scaling and saturating two's-complement fixed-point arithmetic. A valid/ready handshake on both sides, with per-stage bubble collapse, lets stage-to-stage FFT chaining absorb downstream stalls without loss.

## Interface
- DATA_W, 16, width of each real/imag component, signed two's complement
- TW_W, 16, width of each twiddle component, signed Q1.(TW_W-1); range [-1.0, +1.0), so +1.0 is not representable
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept input this cycle
- i_a_re, i_a_im  in  DATA_W each  operand A
- i_b_re, i_b_im  in  DATA_W each  operand B
- i_tw_re, i_tw_im  in  TW_W each  twiddle W
- i_mode  in  1  0 = DIT, 1 = DIF; sampled with each beat
- i_scale  in  1  1 = halve add/sub results; sampled with each beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_x0_re, o_x0_im, o_x1_re, o_x1_im  out  DATA_W each  results
- o_ovf  out  1  sticky saturation flag
- i_clr_ovf  in  1  clears o_ovf

## Operation
- Transfer in when i_valid && o_ready. Transfer out when o_valid && i_ready.
- DIT: P = B·W; X0 = A + P; X1 = A − P.
- DIF: X0 = A + B; D = A − B; X1 = D·W.
- Complex multiply: re = Bre·Wre − Bim·Wim; im = Bre·Wim + Bim·Wre.
  - Full precision is DATA_W+TW_W+1 bits.
  - Round half-up: add 2^(TW_W−2), then arithmetic shift right by TW_W−1.
  - Saturate to DATA_W.
- Add/sub is computed at DATA_W+1 bits.
  - i_scale=1: result = (s + 1) >>> 1, which always fits.
  - i_scale=0: saturate to DATA_W.
- Saturation clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- DIF scaling and saturation apply to D before the multiply.
- o_ovf sets when any saturation occurs in a beat, at the cycle that beat leaves the block.
  - o_ovf clears when i_clr_ovf=1.
  - If set and clear happen in the same cycle, set wins.
- i_mode and i_scale travel with their beat. Mixed modes in flight are legal.

## Timing
- Three register stages S1..S3 with valid bits v1..v3. S3 drives the outputs.
- Latency is 3 cycles from input transfer to o_valid when there is no stall. Throughput is 1 beat/cycle.
- Stage advance rules:
  - adv3 = !v3 | i_ready
  - adv2 = !v2 | adv3
  - adv1 = !v1 | adv2
  - o_ready = adv1, a combinational path from i_ready; this path is accepted.
- Empty stages fill while downstream is stalled (bubble collapse). Capacity is 3 beats.
- While o_valid && !i_ready, all output ports stay stable.
- Reset (i_rst_n=0 at an edge) behaviour:
  - v1..v3 = 0, o_valid = 0.
  - All o_x* = 0, o_ovf = 0.
  - Takes priority over any transfer. In-flight beats are discarded.
  - o_ready = 1 on the first cycle after reset deasserts.
- Data registers need not be reset internally. Output registers must be reset.

## Test plan
- DIT, W=(32767,0), A=(100,50), B=(1000,0), scale 0 -> after 3 cycles X0=(1100,50), X1=(−900,50), o_ovf=0. Repeat with scale 1 -> X0=(550,25), X1=(−450,25).
- DIT, W=(0,−32768) (−j), A=(0,0), B=(1000,200) -> X0=(200,−1000), X1=(−200,1000).
- Saturation: DIT, W=(−32768,0), B=(−32768,0), A=(0,0), scale 0 -> X0=(32767,0), X1=(−32768,0), o_ovf=1. Then i_clr_ovf=1 together with a saturating beat exiting -> o_ovf stays 1.
- DIF, A=(3000,0), B=(1000,0), W=(0,−32768), scale 0 -> X0=(4000,0), X1=(0,−2000).
- Backpressure: stream 8 distinct beats with i_ready=0 for cycles 2–9.
  - o_ready falls after 3 accepted beats.
  - Outputs hold stable while stalled.
  - After release, all 8 results emerge in order with no drop or duplicate. Randomized i_valid/i_ready matches the reference model.
- Reset mid-stream with 3 beats in flight and o_ovf=1 -> next edge: o_valid=0, outputs 0, o_ovf=0; no stale beat ever appears.
